// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared memory-port definitions: access width codes, the
//                captured request record and the dmem sequencer states.
//  Revision    : 1.0
// ============================================================================
package mem_pkg;

   // Access width codes, shared with the hart's load/store unit.
   localparam logic [1:0] MEMW_BYTE = 2'b00;
   localparam logic [1:0] MEMW_HALF = 2'b01;
   localparam logic [1:0] MEMW_WORD = 2'b10;

   typedef logic [1:0] memwidth_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // One complete request as presented on the port.
   typedef struct packed {
      logic [31:0] addr;
      logic        w;
      logic        sext;
      memwidth_t   width;
      logic [31:0] wdata;
   } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane
//  Description : Byte-lane steering for a little-endian 32-bit word: store
//                byte enables and replicated write data, load extraction with
//                sign/zero extension, and alignment check.
//  Revision    : 1.0
// ============================================================================
module mem_lane
   import mem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  memwidth_t   width,
   input  logic        sext,      // 0 = sign-extend, 1 = zero-extend
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  byte_en,
   output logic [31:0] wword,
   output logic [31:0] load_data,
   output logic        misalign
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Pick the addressed byte and half out of the raw read word.
   always_comb begin
      sel_byte = rdata[7:0];
      case (addr_lo)
         2'd0:    sel_byte = rdata[7:0];
         2'd1:    sel_byte = rdata[15:8];
         2'd2:    sel_byte = rdata[23:16];
         default: sel_byte = rdata[31:24];
      endcase
      sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Lane enables, replicated store data, extended load data, alignment.
   always_comb begin
      byte_en   = 4'b0000;
      wword     = wdata;
      load_data = 32'd0;
      misalign  = 1'b0;
      case (width)
         MEMW_BYTE: begin
            byte_en   = 4'b0001 << addr_lo;
            wword     = {4{wdata[7:0]}};
            load_data = sext ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
         end
         MEMW_HALF: begin
            byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
            wword     = {2{wdata[15:0]}};
            load_data = sext ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
            misalign  = addr_lo[0];
         end
         MEMW_WORD: begin
            byte_en   = 4'b1111;
            wword     = wdata;
            load_data = rdata;
            misalign  = (addr_lo != 2'd0);
         end
         default: begin
            // Illegal width: no lanes, no data; the caller flags the fault.
            byte_en   = 4'b0000;
            load_data = 32'd0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dmem.sv
`default_nettype none
// ============================================================================
//  Module      : dmem
//  Description : Data-memory responder for the hart load/store port. One
//                request at a time, fixed response latency, byte-masked
//                stores, extended loads, fault on misalignment/illegal
//                width/out-of-range index.
//  Revision    : 1.0
// ============================================================================
module dmem
   import mem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] memaddr,
   input  logic        memw,
   input  logic        memsext,
   input  logic [1:0]  memwidth,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   output logic [31:0] memdata,
   output logic        fault
);

   localparam int c_addr_w = $clog2(DEPTH);
   localparam int c_cnt_w  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(LATENCY - 1);

   logic [31:0] ram [DEPTH];

   dmem_state_t          state_q, state_d;
   logic [c_cnt_w-1:0]   count_q, count_d;
   dmem_req_t            req_q, req_d;
   logic                 ready_q, ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [31:0]          memdata_q, memdata_d;
   logic                 fault_q, fault_d;

   dmem_req_t            live_req;
   dmem_req_t            cur_req;
   logic                 enter_resp;
   logic [c_addr_w-1:0]  word_idx;
   logic                 out_of_range;
   logic [31:0]          rd_word;
   logic [3:0]           lane_en;
   logic [31:0]          lane_wword;
   logic [31:0]          lane_load;
   logic                 lane_misalign;
   logic                 req_fault;

   assign live_req = '{addr: memaddr, w: memw, sext: memsext, width: memwidth, wdata: wdata};

   // With LATENCY = 1 the access happens on the accepting edge itself, so
   // the live port is used in IDLE; otherwise the captured copy is used.
   always_comb begin
      cur_req      = (state_q == IDLE) ? live_req : req_q;
      word_idx     = cur_req.addr[c_addr_w+1:2];
      out_of_range = |cur_req.addr[31:c_addr_w+2];
      rd_word      = ram[word_idx];
      req_fault    = lane_misalign || (cur_req.width == 2'b11) || out_of_range;
   end

   mem_lane u_lane (
      .addr_lo   (cur_req.addr[1:0]),
      .width     (cur_req.width),
      .sext      (cur_req.sext),
      .wdata     (cur_req.wdata),
      .rdata     (rd_word),
      .byte_en   (lane_en),
      .wword     (lane_wword),
      .load_data (lane_load),
      .misalign  (lane_misalign)
   );

   // Sequencer next state; the access is performed on the edge entering RESP.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      req_d       = req_q;
      ready_d     = ready_q;
      rsp_valid_d = 1'b0;
      memdata_d   = 32'd0;
      fault_d     = 1'b0;
      enter_resp  = 1'b0;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (ready_q && req_valid) begin
               req_d   = live_req;
               ready_d = 1'b0;
               if (LATENCY == 1) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  count_d = c_cnt_init;
               end
            end
         end
         WAIT: begin
            ready_d = 1'b0;
            if (count_q <= c_cnt_w'(1)) begin
               state_d    = RESP;
               enter_resp = 1'b1;
               count_d    = '0;
            end else begin
               count_d = count_q - c_cnt_w'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b0;
         end
      endcase
      if (enter_resp) begin
         rsp_valid_d = 1'b1;
         fault_d     = req_fault;
         memdata_d   = (!cur_req.w && !req_fault) ? lane_load : 32'd0;
      end
   end

   // Sequencer and registered response outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         req_q       <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         memdata_q   <= 32'd0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         req_q       <= req_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         memdata_q   <= memdata_d;
         fault_q     <= fault_d;
      end
   end

   // Byte-masked store commit; RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (enter_resp && cur_req.w && !req_fault) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               ram[word_idx][8*i +: 8] <= lane_wword[8*i +: 8];
            end
         end
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign memdata   = memdata_q;
   assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem
//  Description : Self-checking bench for dmem: one instance at LATENCY = 1
//                and one at LATENCY = 3, table vectors, random traffic
//                against a byte-array reference, throughput and reset cases.
//  Revision    : 1.0
// ============================================================================
module tb_dmem;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst1, rst3, valid1, valid3;
   logic [31:0] memaddr, wdata;
   logic        memw, memsext;
   logic [1:0]  memwidth;
   logic        ready1, rsp1, fault1, ready3, rsp3, fault3;
   logic [31:0] data1, data3;

   always #5 clk = ~clk;

   dmem #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(rst1), .req_valid(valid1), .req_ready(ready1),
      .memaddr(memaddr), .memw(memw), .memsext(memsext), .memwidth(memwidth),
      .wdata(wdata), .rsp_valid(rsp1), .memdata(data1), .fault(fault1));

   dmem #(.DEPTH(DEPTH), .LATENCY(3)) u_dut3 (
      .clk(clk), .reset(rst3), .req_valid(valid3), .req_ready(ready3),
      .memaddr(memaddr), .memw(memw), .memsext(memsext), .memwidth(memwidth),
      .wdata(wdata), .rsp_valid(rsp3), .memdata(data3), .fault(fault3));

   int tests = 0;
   int fails = 0;

   // Reference memory for the LATENCY = 1 instance, one entry per byte.
   logic [7:0] mb [4*DEPTH];

   typedef struct {
      logic [31:0] addr;
      logic        w;
      logic        s;
      logic [1:0]  wd;
      logic [31:0] d;
      logic [31:0] ed;
      logic        ef;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   // Reference behaviour: plain little-endian byte array.
   task automatic model(input logic [31:0] a, input logic w, input logic s,
                        input logic [1:0] wd, input logic [31:0] d,
                        output logic [31:0] ed, output logic ef);
      int n;
      n  = (wd == 2'd0) ? 1 : (wd == 2'd1) ? 2 : 4;
      ef = (wd == 2'd3) || ((a % n) != 0) || ((a / 4) >= 32'(DEPTH));
      ed = 32'd0;
      if (!ef) begin
         if (w) begin
            for (int k = 0; k < n; k++) mb[a+k] = d[8*k +: 8];
         end else begin
            for (int k = 0; k < n; k++) ed[8*k +: 8] = mb[a+k];
            if (n < 4 && !s && ed[8*n-1]) begin
               for (int k = n; k < 4; k++) ed[8*k +: 8] = 8'hFF;
            end
         end
      end
   endtask

   // One request/response; starts and ends 1 ns after a rising edge.
   // lat = number of post-edge samples from acceptance to rsp_valid.
   task automatic xact(input bit l3, input logic [31:0] a, input logic w, input logic s,
                       input logic [1:0] wd, input logic [31:0] d,
                       output logic [31:0] rd, output logic rf, output int lat);
      int guard = 0;
      memaddr = a; memw = w; memsext = s; memwidth = wd; wdata = d;
      if (l3) valid3 = 1'b1; else valid1 = 1'b1;
      while (!(l3 ? ready3 : ready1) && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      rd = 32'd0; rf = 1'b0; lat = -1;
      if (guard >= 50) begin
         tests++; fails++;
         $display("FAIL ready_timeout: actual 0 required 1");
         valid1 = 1'b0; valid3 = 1'b0;
         return;
      end
      @(posedge clk); #1;
      valid1 = 1'b0; valid3 = 1'b0;
      // Scramble request inputs: they must be ignored after acceptance.
      memaddr = $urandom; memw = 1'($urandom); memsext = 1'($urandom);
      memwidth = 2'($urandom); wdata = $urandom;
      lat = 1;
      while (!(l3 ? rsp3 : rsp1) && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      rd = l3 ? data3 : data1;
      rf = l3 ? fault3 : fault1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, ed;
      logic        rf, ef;
      int          lat;
      int          acc [3];
      int          nacc, pulses, rdy_bad, last_acc;

      rst1 = 1'b1; rst3 = 1'b1; valid1 = 1'b0; valid3 = 1'b0;
      memaddr = '0; wdata = '0; memw = 1'b0; memsext = 1'b0; memwidth = 2'd0;

      tbl[0]  = '{32'h10, 1'b1, 1'b0, 2'd2, 32'hDEADBEEF, 32'h0,        1'b0};
      tbl[1]  = '{32'h10, 1'b0, 1'b0, 2'd2, 32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2]  = '{32'h13, 1'b0, 1'b0, 2'd0, 32'h0,        32'hFFFFFFDE, 1'b0};
      tbl[3]  = '{32'h13, 1'b0, 1'b1, 2'd0, 32'h0,        32'h000000DE, 1'b0};
      tbl[4]  = '{32'h12, 1'b0, 1'b0, 2'd1, 32'h0,        32'hFFFFDEAD, 1'b0};
      tbl[5]  = '{32'h10, 1'b1, 1'b0, 2'd1, 32'h00001234, 32'h0,        1'b0};
      tbl[6]  = '{32'h13, 1'b1, 1'b0, 2'd0, 32'hABCDEF77, 32'h0,        1'b0};
      tbl[7]  = '{32'h10, 1'b0, 1'b0, 2'd2, 32'h0,        32'h77AD1234, 1'b0};
      tbl[8]  = '{32'h11, 1'b1, 1'b0, 2'd2, 32'h11111111, 32'h0,        1'b1};
      tbl[9]  = '{32'h10, 1'b0, 1'b0, 2'd2, 32'h0,        32'h77AD1234, 1'b0};
      tbl[10] = '{32'h10, 1'b0, 1'b0, 2'd3, 32'h0,        32'h0,        1'b1};
      tbl[11] = '{32'h100,1'b0, 1'b0, 2'd2, 32'h0,        32'h0,        1'b1};
      tbl[12] = '{32'h11, 1'b1, 1'b0, 2'd1, 32'h5555AAAA, 32'h0,        1'b1};
      tbl[13] = '{32'h12, 1'b0, 1'b0, 2'd0, 32'h0,        32'hFFFFFFAD, 1'b0};
      tbl[14] = '{32'h10, 1'b0, 1'b1, 2'd1, 32'h0,        32'h00001234, 1'b0};
      tbl[15] = '{32'h12, 1'b0, 1'b1, 2'd1, 32'h0,        32'h000077AD, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready1", {31'd0, ready1}, 32'd0);
      chk("rst_rsp1",   {31'd0, rsp1},   32'd0);
      chk("rst_data1",  data1,           32'd0);
      chk("rst_fault1", {31'd0, fault1}, 32'd0);
      chk("rst_ready3", {31'd0, ready3}, 32'd0);
      @(negedge clk);
      rst1 = 1'b0; rst3 = 1'b0;
      @(posedge clk); #1;
      chk("rel_ready1", {31'd0, ready1}, 32'd1);
      chk("rel_ready3", {31'd0, ready3}, 32'd1);

      // Table vectors on the LATENCY = 1 instance
      for (int i = 0; i < 16; i++) begin
         model(tbl[i].addr, tbl[i].w, tbl[i].s, tbl[i].wd, tbl[i].d, ed, ef);
         xact(1'b0, tbl[i].addr, tbl[i].w, tbl[i].s, tbl[i].wd, tbl[i].d, rd, rf, lat);
         chk($sformatf("vec%0d_data", i),  rd, tbl[i].ed);
         chk($sformatf("vec%0d_fault", i), {31'd0, rf}, {31'd0, tbl[i].ef});
         chk($sformatf("vec%0d_lat", i),   lat, 32'd1);
      end

      // Fill every word so random loads never see uninitialised RAM
      for (int i = 0; i < DEPTH; i++) begin
         logic [31:0] v;
         v = $urandom;
         model(32'(4*i), 1'b1, 1'b0, 2'd2, v, ed, ef);
         xact(1'b0, 32'(4*i), 1'b1, 1'b0, 2'd2, v, rd, rf, lat);
      end
      chk("fill_fault", {31'd0, rf}, 32'd0);

      // Random traffic against the reference
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a, d;
         logic        w, s;
         logic [1:0]  wd;
         a  = $urandom_range(0, 4*DEPTH + 15);
         wd = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         w  = 1'($urandom);
         s  = 1'($urandom);
         d  = $urandom;
         model(a, w, s, wd, d, ed, ef);
         xact(1'b0, a, w, s, wd, d, rd, rf, lat);
         chk($sformatf("rnd%0d_data", i),  rd, ed);
         chk($sformatf("rnd%0d_fault", i), {31'd0, rf}, {31'd0, ef});
         chk($sformatf("rnd%0d_lat", i),   lat, 32'd1);
      end

      // LATENCY = 3: baseline store, then back-to-back loads with valid held
      xact(1'b1, 32'h20, 1'b1, 1'b0, 2'd2, 32'hA5A55A5A, rd, rf, lat);
      chk("l3_store_lat",   lat, 32'd3);
      chk("l3_store_fault", {31'd0, rf}, 32'd0);
      @(posedge clk); #1;
      memaddr = 32'h20; memw = 1'b0; memsext = 1'b0; memwidth = 2'd2;
      valid3 = 1'b1;
      nacc = 0; pulses = 0; rdy_bad = 0; last_acc = -100;
      acc[0] = -100; acc[1] = -100; acc[2] = -100;
      for (int cyc = 0; cyc < 14; cyc++) begin
         if (nacc == 3) valid3 = 1'b0;
         if (rsp3) begin
            pulses++;
            chk("t5_data", data3, 32'hA5A55A5A);
            chk("t5_rsp_pos", cyc - last_acc, 32'd3);
         end
         if (ready3 && (cyc - last_acc) >= 1 && (cyc - last_acc) <= 3) rdy_bad++;
         if (ready3 && valid3) begin
            if (nacc < 3) acc[nacc] = cyc;
            nacc++;
            last_acc = cyc;
         end
         @(posedge clk); #1;
      end
      valid3 = 1'b0;
      chk("t5_accepts",  nacc, 32'd3);
      chk("t5_space1",   acc[1] - acc[0], 32'd4);
      chk("t5_space2",   acc[2] - acc[1], 32'd4);
      chk("t5_pulses",   pulses, 32'd3);
      chk("t5_ready_lo", rdy_bad, 32'd0);

      // LATENCY = 3: reset one cycle after accepting a store
      memaddr = 32'h20; memw = 1'b1; memsext = 1'b0; memwidth = 2'd2; wdata = 32'hCAFEF00D;
      valid3 = 1'b1;
      for (int g = 0; g < 20 && !ready3; g++) begin
         @(posedge clk); #1;
      end
      chk("t6_ready", {31'd0, ready3}, 32'd1);
      @(posedge clk); #1;
      valid3 = 1'b0;
      pulses = 0;
      @(posedge clk); #2;
      rst3 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (rsp3) pulses++;
      end
      chk("t6_rst_ready", {31'd0, ready3}, 32'd0);
      chk("t6_rst_data",  data3, 32'd0);
      @(negedge clk);
      rst3 = 1'b0;
      @(posedge clk); #1;
      if (rsp3) pulses++;
      chk("t6_rel_ready", {31'd0, ready3}, 32'd1);
      chk("t6_no_rsp",    pulses, 32'd0);
      xact(1'b1, 32'h20, 1'b0, 1'b0, 2'd2, 32'h0, rd, rf, lat);
      chk("t6_mem_kept",  rd, 32'hA5A55A5A);
      chk("t6_load_lat",  lat, 32'd3);
      chk("t6_fault",     {31'd0, rf}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
